// File: rtl/aes_multi_core_ctrl.sv
// Round-robin dispatcher and in-order retirer between the UART rx/tx buffers and NUM_CORES AES engines.
// Optional feature macro AES_CTRL_STALL_CNT_EN adds the stall_cycles output.
module aes_multi_core_ctrl #(
    parameter int BLOCK_W   = 128,
    parameter int NUM_CORES = 2,
    parameter int PTR_W     = 3,
    parameter int CNT_W     = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [BLOCK_W-1:0]             pt,
    input  logic                           rx_empty,
    output logic                           rx_read,
    input  logic                           tx_overflow,
    output logic                           tx_write,
    output logic [BLOCK_W-1:0]             ct,
    input  logic [NUM_CORES-1:0]           aes_ready,
    output logic [NUM_CORES-1:0]           aes_start,
    output logic [NUM_CORES*BLOCK_W-1:0]   pt_to_aes,
    input  logic [NUM_CORES*BLOCK_W-1:0]   ct_from_aes,
    output logic [CNT_W-1:0]               blocks_done,
    output logic                           busy
`ifdef AES_CTRL_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0]               stall_cycles
`endif
);

    typedef enum logic [1:0] {S_FREE, S_LOAD, S_RUN, S_DONE} slot_t;

    slot_t                slot_q   [NUM_CORES];
    logic [BLOCK_W-1:0]   result_q [NUM_CORES];
    logic [NUM_CORES-1:0] armed_q;
    logic [PTR_W-1:0]     disp_ptr;
    logic [PTR_W-1:0]     ret_ptr;
    logic                 run_en;

    logic [NUM_CORES-1:0] disp_hot;
    logic [NUM_CORES-1:0] ret_hot;
    logic [NUM_CORES-1:0] slot_free;
    logic [NUM_CORES-1:0] slot_done;
    logic [NUM_CORES-1:0] keep_busy;
    logic                 head_done;
    logic                 dispatch_en;
    logic                 retire_en;
    logic [BLOCK_W-1:0]   ret_result;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(NUM_CORES - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Pointers are decoded to one-hot so slots are never indexed out of range.
    always_comb begin
        disp_hot   = '0;
        ret_hot    = '0;
        slot_free  = '0;
        slot_done  = '0;
        keep_busy  = '0;
        ret_result = '0;
        for (int unsigned k = 0; k < NUM_CORES; k++) begin
            disp_hot[k]  = (disp_ptr == PTR_W'(k));
            ret_hot[k]   = (ret_ptr == PTR_W'(k));
            slot_free[k] = (slot_q[k] == S_FREE);
            slot_done[k] = (slot_q[k] == S_DONE);
            if (ret_hot[k]) ret_result = result_q[k];
        end
        head_done   = |(ret_hot & slot_done);
        dispatch_en = run_en && !rx_empty && (|(disp_hot & slot_free & aes_ready));
        retire_en   = head_done && !tx_overflow;
        for (int unsigned k = 0; k < NUM_CORES; k++) begin
            case (slot_q[k])
                S_FREE:  keep_busy[k] = dispatch_en && disp_hot[k];
                S_DONE:  keep_busy[k] = !(retire_en && ret_hot[k]);
                default: keep_busy[k] = 1'b1;
            endcase
        end
    end

    // rx_read is combinational so the head block is popped in the same cycle it is captured.
    assign rx_read = dispatch_en;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run_en      <= 1'b0;
            disp_ptr    <= '0;
            ret_ptr     <= '0;
            tx_write    <= 1'b0;
            ct          <= '0;
            aes_start   <= '0;
            pt_to_aes   <= '0;
            blocks_done <= '0;
            busy        <= 1'b0;
            armed_q     <= '0;
            for (int unsigned k = 0; k < NUM_CORES; k++) begin
                slot_q[k]   <= S_FREE;
                result_q[k] <= '0;
            end
        end else begin
            run_en    <= 1'b1;
            tx_write  <= 1'b0;
            aes_start <= '0;
            busy      <= |keep_busy;
            for (int unsigned k = 0; k < NUM_CORES; k++) begin
                case (slot_q[k])
                    S_FREE: begin
                        if (dispatch_en && disp_hot[k]) begin
                            pt_to_aes[k*BLOCK_W +: BLOCK_W] <= pt;
                            aes_start[k] <= 1'b1;
                            slot_q[k]    <= S_LOAD;
                        end
                    end
                    S_LOAD: begin
                        slot_q[k]  <= S_RUN;
                        armed_q[k] <= 1'b0;
                    end
                    S_RUN: begin
                        // First RUN cycle ignores aes_ready: the engine may still show its idle flag.
                        if (!armed_q[k]) begin
                            armed_q[k] <= 1'b1;
                        end else if (aes_ready[k]) begin
                            result_q[k] <= ct_from_aes[k*BLOCK_W +: BLOCK_W];
                            slot_q[k]   <= S_DONE;
                        end
                    end
                    S_DONE: begin
                        if (retire_en && ret_hot[k]) slot_q[k] <= S_FREE;
                    end
                    default: slot_q[k] <= S_FREE;
                endcase
            end
            if (dispatch_en) disp_ptr <= ptr_inc(disp_ptr);
            if (retire_en) begin
                ct          <= ret_result;
                tx_write    <= 1'b1;
                ret_ptr     <= ptr_inc(ret_ptr);
                blocks_done <= blocks_done + CNT_W'(1);
            end
        end
    end

`ifdef AES_CTRL_STALL_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cycles <= '0;
        end else if (head_done && tx_overflow && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end
`endif

endmodule

// File: doc/aes_multi_core_ctrl.md
Name: aes_multi_core_ctrl

Overview:
- Parametrised successor of the single-engine sequencer between rx_buffer, AES engines and tx_buffer.
- Drives NUM_CORES AES engines in parallel:
  - dispatches plaintext blocks round-robin;
  - retires ciphertext to tx_buffer strictly in arrival order.
- Sits in the communication module between the UART rx/tx buffers and the AES core array.

Parameters:
- BLOCK_W, 128: plaintext/ciphertext block width in bits.
- NUM_CORES, 2: number of AES engines driven (1..8).
- PTR_W, 3: slot pointer width; must satisfy 2**PTR_W >= NUM_CORES.
- CNT_W, 16: width of the retired-block counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- pt  in  BLOCK_W  block at head of rx_buffer.
- rx_empty  in  1  rx_buffer has no block.
- rx_read  out  1  one-cycle pop pulse to rx_buffer.
- tx_overflow  in  1  tx_buffer cannot accept a write.
- tx_write  out  1  one-cycle push pulse to tx_buffer.
- ct  out  BLOCK_W  ciphertext; valid in the cycle tx_write=1.
- aes_ready  in  NUM_CORES  per-core idle/done flag.
- aes_start  out  NUM_CORES  per-core one-cycle start pulse.
- pt_to_aes  out  NUM_CORES*BLOCK_W  per-core plaintext; slice k = bits [k*BLOCK_W +: BLOCK_W].
- ct_from_aes  in  NUM_CORES*BLOCK_W  per-core ciphertext, same slicing.
- blocks_done  out  CNT_W  count of blocks written to tx_buffer.
- busy  out  1  high while any slot is not FREE.

Behaviour:
- Reset (reset=0, asynchronous):
  - all outputs 0; all slots FREE; disp_ptr=0, ret_ptr=0; blocks_done=0.
  - In-flight blocks are dropped, including on reset mid-operation. No pulse is issued in the first cycle after release.
- Each core k owns a slot with states FREE, LOAD, RUN, DONE and a BLOCK_W result register.
- Dispatch, cycle N:
  - Condition: slot[disp_ptr]==FREE, rx_empty=0 and aes_ready[disp_ptr]=1.
  - Action: pt_to_aes slice <= pt; rx_read=1; slot -> LOAD; disp_ptr <= (disp_ptr+1) mod NUM_CORES.
  - At most one dispatch per cycle.
- LOAD:
  - Cycle N+1: aes_start[k]=1; slot -> RUN.
  - pt_to_aes slice is held stable until the slot is next dispatched.
- RUN:
  - aes_ready[k] is ignored in the cycle immediately after aes_start.
  - From the following cycle, aes_ready[k]=1 captures ct_from_aes slice into the result register; slot -> DONE.
- Retire, cycle M:
  - Condition: slot[ret_ptr]==DONE and tx_overflow=0.
  - Action: ct <= result; tx_write=1; slot -> FREE; ret_ptr <= (ret_ptr+1) mod NUM_CORES; blocks_done+1 (wraps at 2**CNT_W).
- Ordering: a DONE slot that is not at ret_ptr holds its result; out-of-order completion never reorders output.
- Same-cycle events:
  - Dispatch and retire on different slots in one cycle are both performed.
  - A slot freed by retire in cycle M is dispatchable no earlier than M+1.
- Stalls:
  - tx_overflow=1 holds ret_ptr; engines keep completing into DONE.
  - Dispatch stalls naturally when slot[disp_ptr] is not FREE.
- Pulse hygiene:
  - rx_read, tx_write and aes_start are single-cycle and default to 0 every cycle.
  - ct holds its last value when tx_write=0.
- busy is registered: it is 1 from the cycle after the first dispatch until the cycle after the last retire.
- NUM_CORES=1 reproduces single-engine behaviour with one extra cycle of dispatch/retire overlap.

Optional Feature:
- Macro: AES_CTRL_STALL_CNT_EN.
- Defined:
  - Adds output stall_cycles (CNT_W). It increments each cycle in which slot[ret_ptr]==DONE and tx_overflow=1.
  - It saturates at all-ones and is cleared by reset.
- Undefined: port and logic absent; the remaining behaviour is identical.

Test Plan:
- NUM_CORES=2, single block pt=128'h00112233445566778899aabbccddeeff, ready model with 10-cycle latency -> rx_read at N, aes_start[0] at N+1, tx_write with ct = model output once, blocks_done=1, busy back to 0.
- Four blocks back-to-back, core1 latency 3 and core0 latency 12 -> tx order is block0, block1, block2, block3; no aes_start to a non-FREE slot.
- tx_overflow held high 20 cycles with both slots DONE -> no tx_write; rx_read stops after 2 dispatches. On release, two tx_writes in consecutive cycles; with AES_CTRL_STALL_CNT_EN, stall_cycles=20.
- Reset asserted asynchronously mid-RUN on both cores -> all outputs 0 immediately. After release, the next block dispatches to core 0 and blocks_done restarts from 0.
- CNT_W=4, 17 blocks -> blocks_done wraps to 1.
- rx_empty toggling every cycle with aes_ready always 1 -> rx_read only when rx_empty=0; aes_start exactly one cycle after each rx_read on the matching core.
